// File: rtl/fpadd_share_arbiter_if.sv
// Bundle of requester, shared-adder and response signals for fpadd_share_arbiter.
// slave: the arbiter side. master: requesters plus the shared adder.
interface fpadd_share_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*16-1:0] req_a;
  logic [NUM_REQ*16-1:0] req_b;
  logic [NUM_REQ-1:0]    req_op;

  logic                  add_in_valid;
  logic [15:0]           add_a;
  logic [15:0]           add_b;
  logic                  add_op;
  logic [15:0]           add_result;
  logic [4:0]            add_flags;

  logic [NUM_REQ-1:0]    rsp_valid;
  logic [15:0]           rsp_data;
  logic [4:0]            rsp_flags;
  logic                  busy;

  modport slave (
    input  req_valid, req_a, req_b, req_op, add_result, add_flags,
    output req_ready, add_in_valid, add_a, add_b, add_op, rsp_valid, rsp_data, rsp_flags, busy
  );

  modport master (
    output req_valid, req_a, req_b, req_op, add_result, add_flags,
    input  req_ready, add_in_valid, add_a, add_b, add_op, rsp_valid, rsp_data, rsp_flags, busy
  );
endinterface

// File: rtl/fpadd_share_arbiter.sv
// Round-robin arbiter sharing one fixed-latency FP16 add/sub unit among NUM_REQ requesters.
// A tag pipeline tracks which requester owns each in-flight result; per-requester credit
// counters cap the number of outstanding operations.
module fpadd_share_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned PIPE_LAT = 5,
  parameter int unsigned MAX_OUT  = 2
) (
  input logic                  clk,
  input logic                  resetn,
  fpadd_share_arbiter_if.slave bus
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUT + 1);

  logic [IdxW-1:0]                ptr_q, ptr_d;
  logic [NUM_REQ-1:0][CntW-1:0]   cnt_q, cnt_d;
  logic [PIPE_LAT:0]              tag_vld_q;
  logic [PIPE_LAT:0][IdxW-1:0]    tag_idx_q;
  logic                           add_in_valid_q;
  logic [15:0]                    add_a_q, add_b_q;
  logic                           add_op_q;

  logic [NUM_REQ-1:0]             rsp_hit;
  logic [NUM_REQ-1:0]             elig;
  logic                           gnt_vld;
  logic [IdxW-1:0]                gnt_idx;
  logic [NUM_REQ-1:0]             gnt_oh;
  logic [15:0]                    sel_a, sel_b;
  logic                           sel_op;

  // Decode the tag leaving the last stage into a one-hot response.
  always_comb begin
    rsp_hit = '0;
    if (tag_vld_q[PIPE_LAT]) rsp_hit[tag_idx_q[PIPE_LAT]] = 1'b1;
  end

  // A requester whose response returns this cycle frees a slot it may reuse immediately.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      elig[i] = (cnt_q[i] < CntW'(MAX_OUT)) || rsp_hit[i];
    end
  end

  // Round-robin search from the pointer; ineligible requesters are skipped.
  always_comb begin
    int unsigned cand;
    cand    = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(ptr_q) + k) % NUM_REQ;
      if (!gnt_vld && bus.req_valid[cand] && elig[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = IdxW'(cand);
      end
    end
    // No acceptance while reset is held.
    if (!resetn) gnt_vld = 1'b0;
  end

  // Grant one-hot, granted operand slice and next pointer.
  always_comb begin
    gnt_oh = '0;
    if (gnt_vld) gnt_oh[gnt_idx] = 1'b1;
    sel_a  = bus.req_a[32'(gnt_idx) * 16 +: 16];
    sel_b  = bus.req_b[32'(gnt_idx) * 16 +: 16];
    sel_op = bus.req_op[gnt_idx];
    ptr_d  = ptr_q;
    if (gnt_vld) begin
      ptr_d = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + IdxW'(1);
    end
  end

  // Outstanding counters: +1 on grant, -1 on response, unchanged when both coincide.
  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_oh[i] && !rsp_hit[i]) begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end else if (!gnt_oh[i] && rsp_hit[i]) begin
        cnt_d[i] = cnt_q[i] - CntW'(1);
      end
    end
  end

  // State: pointer, counters, tag pipeline and registered adder issue.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q          <= '0;
      cnt_q          <= '0;
      tag_vld_q      <= '0;
      tag_idx_q      <= '0;
      add_in_valid_q <= 1'b0;
      add_a_q        <= '0;
      add_b_q        <= '0;
      add_op_q       <= 1'b0;
    end else begin
      ptr_q          <= ptr_d;
      cnt_q          <= cnt_d;
      tag_vld_q[0]   <= gnt_vld;
      tag_idx_q[0]   <= gnt_idx;
      for (int unsigned k = 1; k <= PIPE_LAT; k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
        tag_idx_q[k] <= tag_idx_q[k-1];
      end
      add_in_valid_q <= gnt_vld;
      if (gnt_vld) begin
        add_a_q  <= sel_a;
        add_b_q  <= sel_b;
        add_op_q <= sel_op;
      end
    end
  end

  assign bus.req_ready    = gnt_oh;
  assign bus.add_in_valid = add_in_valid_q;
  assign bus.add_a        = add_a_q;
  assign bus.add_b        = add_b_q;
  assign bus.add_op       = add_op_q;
  assign bus.rsp_valid    = rsp_hit;
  assign bus.rsp_data     = (|rsp_hit) ? bus.add_result : 16'h0000;
  assign bus.rsp_flags    = (|rsp_hit) ? bus.add_flags : 5'h00;
  assign bus.busy         = (|tag_vld_q) | add_in_valid_q;

endmodule

// File: tb/tb_fpadd_share_arbiter.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and a randomized
// phase, all checked against a cycle-level model built on counts and a response queue.
module tb_fpadd_share_arbiter;
  localparam int N    = 4;
  localparam int LAT  = 5;
  localparam int MAXO = 2;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  fpadd_share_arbiter_if #(.NUM_REQ(N)) bus ();

  fpadd_share_arbiter #(
    .NUM_REQ (N),
    .PIPE_LAT(LAT),
    .MAX_OUT (MAXO)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Stand-in adder: 1.0+2.0 is real; everything else is a reversible mix so a result
  // routed to the wrong requester or built from the wrong operands is visible.
  function automatic logic [15:0] add_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic op);
    if (a == 16'h3C00 && b == 16'h4000 && !op) return 16'h4200;
    return a ^ {b[7:0], b[15:8]} ^ {op, 15'd0};
  endfunction

  function automatic logic [4:0] flg_fn(input logic [15:0] a, input logic [15:0] b,
                                        input logic op);
    return a[4:0] ^ b[9:5] ^ {4'd0, op};
  endfunction

  // Shared adder: fixed LAT cycles from add_in_valid, never reset, garbage when idle.
  logic [LAT-1:0] sp_v = '0;
  logic [15:0]    sp_r [LAT];
  logic [4:0]     sp_f [LAT];
  always @(posedge clk) begin
    sp_v[0] <= bus.add_in_valid;
    sp_r[0] <= add_fn(bus.add_a, bus.add_b, bus.add_op);
    sp_f[0] <= flg_fn(bus.add_a, bus.add_b, bus.add_op);
    for (int k = 1; k < LAT; k++) begin
      sp_v[k] <= sp_v[k-1];
      sp_r[k] <= sp_r[k-1];
      sp_f[k] <= sp_f[k-1];
    end
  end
  assign bus.add_result = sp_v[LAT-1] ? sp_r[LAT-1] : 16'hDEAD;
  assign bus.add_flags  = sp_v[LAT-1] ? sp_f[LAT-1] : 5'h1F;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: pointer, outstanding counts, queue of responses due.
  typedef struct {
    int          due;
    int          idx;
    logic [15:0] d;
    logic [4:0]  f;
  } rsp_t;
  rsp_t        q[$];
  int          m_ptr;
  int          m_cnt[N];
  int          prev_g;
  logic [15:0] prev_a, prev_b;
  logic        prev_op;

  task automatic model_reset();
    q.delete();
    m_ptr  = 0;
    prev_g = -1;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  // Called at the falling edge: compare, advance the model, move to just after the next rise.
  task automatic model_step();
    logic [N-1:0] e_rdy;
    logic [N-1:0] e_rv;
    logic [15:0]  e_d, ga, gb;
    logic [4:0]   e_f;
    logic         gop;
    int           g, r, i;
    e_rdy = '0; e_rv = '0; e_d = '0; e_f = '0; g = -1; r = -1;
    if (q.size() > 0 && q[0].due == cyc) begin
      r = q[0].idx; e_rv[r] = 1'b1; e_d = q[0].d; e_f = q[0].f;
    end
    for (int k = 0; k < N; k++) begin
      i = (m_ptr + k) % N;
      if (g < 0 && bus.req_valid[i] && (m_cnt[i] < MAXO || r == i)) g = i;
    end
    if (g >= 0) e_rdy[g] = 1'b1;
    chk("req_ready", 32'(bus.req_ready), 32'(e_rdy));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
    chk("rsp_data", 32'(bus.rsp_data), 32'(e_d));
    chk("rsp_flags", 32'(bus.rsp_flags), 32'(e_f));
    chk("busy", 32'(bus.busy), 32'(q.size() > 0));
    chk("add_in_valid", 32'(bus.add_in_valid), 32'(prev_g >= 0));
    if (prev_g >= 0) begin
      chk("add_a", 32'(bus.add_a), 32'(prev_a));
      chk("add_b", 32'(bus.add_b), 32'(prev_b));
      chk("add_op", 32'(bus.add_op), 32'(prev_op));
    end
    if (r >= 0) begin
      void'(q.pop_front());
      m_cnt[r]--;
    end
    prev_g = g;
    if (g >= 0) begin
      ga = bus.req_a[g*16 +: 16];
      gb = bus.req_b[g*16 +: 16];
      gop = bus.req_op[g];
      prev_a = ga; prev_b = gb; prev_op = gop;
      m_cnt[g]++;
      m_ptr = (g + 1) % N;
      q.push_back('{cyc + 1 + LAT, g, add_fn(ga, gb, gop), flg_fn(ga, gb, gop)});
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
  endtask

  // Called just after a rising edge: asserts reset, checks the outputs, releases.
  task automatic do_reset();
    bus.req_valid = '1;
    resetn = 1'b0;
    #2;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_add_in_valid", 32'(bus.add_in_valid), 32'd0);
    chk("rst_add_a", 32'(bus.add_a), 32'd0);
    chk("rst_add_b", 32'(bus.add_b), 32'd0);
    chk("rst_add_op", 32'(bus.add_op), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    bus.req_valid = '0;
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic renew(input int i);
    bus.req_a[i*16 +: 16] = 16'($urandom);
    bus.req_b[i*16 +: 16] = 16'($urandom);
    bus.req_op[i]         = 1'($urandom);
  endtask

  task automatic drain();
    bus.req_valid = '0;
    for (int k = 0; k < LAT + 2; k++) cycle();
  endtask

  typedef struct {
    logic [N-1:0] v;
    logic [15:0]  a;
    logic [15:0]  b;
    logic         op;
    logic [N-1:0] exp_rdy;
    logic [15:0]  exp_d;
  } vec_t;
  vec_t tbl[6];

  initial begin
    logic [N-1:0] exp;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    model_reset();

    // Slice i carries a ^ (i << 12), so the expected data pins down the granted slice.
    tbl[0] = '{4'b0001, 16'h3C00, 16'h4000, 1'b0, 4'b0001, 16'h4200};
    tbl[1] = '{4'b0110, 16'h1234, 16'h00FF, 1'b1, 4'b0010, add_fn(16'h1234 ^ 16'h1000, 16'h00FF, 1'b1)};
    tbl[2] = '{4'b1000, 16'h0A5A, 16'h3333, 1'b0, 4'b1000, add_fn(16'h0A5A ^ 16'h3000, 16'h3333, 1'b0)};
    tbl[3] = '{4'b1111, 16'h0BCD, 16'h7001, 1'b1, 4'b0001, add_fn(16'h0BCD, 16'h7001, 1'b1)};
    tbl[4] = '{4'b1100, 16'h0F0F, 16'hC3C3, 1'b0, 4'b0100, add_fn(16'h0F0F ^ 16'h2000, 16'hC3C3, 1'b0)};
    tbl[5] = '{4'b0000, 16'h0111, 16'h0222, 1'b0, 4'b0000, 16'h0000};

    @(posedge clk);
    #1;
    for (int t = 0; t < 6; t++) begin
      do_reset();
      for (int i = 0; i < N; i++) begin
        bus.req_a[i*16 +: 16] = tbl[t].a ^ (16'(i) << 12);
        bus.req_b[i*16 +: 16] = tbl[t].b;
        bus.req_op[i]         = tbl[t].op;
      end
      bus.req_valid = tbl[t].v;
      @(negedge clk);
      chk("tbl_ready", 32'(bus.req_ready), 32'(tbl[t].exp_rdy));
      model_step();
      bus.req_valid = '0;
      for (int k = 0; k < LAT; k++) cycle();
      @(negedge clk);
      chk("tbl_rsp_valid", 32'(bus.rsp_valid), 32'(tbl[t].exp_rdy));
      chk("tbl_rsp_data", 32'(bus.rsp_data), 32'(tbl[t].exp_d));
      model_step();
    end

    // All requesters valid: strict rotation, one grant per cycle.
    do_reset();
    for (int i = 0; i < N; i++) renew(i);
    bus.req_valid = '1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("rr_order", 32'(bus.req_ready), 32'(1) << (c % 4));
      model_step();
      if (prev_g >= 0) renew(prev_g);
    end
    drain();

    // Single requester hits its credit limit, then reuses each returning slot.
    do_reset();
    renew(2);
    bus.req_valid = 4'b0100;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      chk("credit_stall", 32'(bus.req_ready), (c % 6 < 2) ? 32'h4 : 32'h0);
      model_step();
      if (prev_g >= 0) renew(prev_g);
    end
    drain();

    // Ineligible requester at the pointer is skipped without taking priority.
    do_reset();
    for (int i = 0; i < N; i++) renew(i);
    bus.req_valid = 4'b0010;
    cycle();
    renew(1);
    cycle();
    bus.req_valid = 4'b0001;
    cycle();
    bus.req_valid = 4'b1010;
    @(negedge clk);
    chk("skip_inelig", 32'(bus.req_ready), 32'h8);
    model_step();
    renew(0);
    bus.req_valid = 4'b1001;
    @(negedge clk);
    chk("ptr_after_skip", 32'(bus.req_ready), 32'h1);
    model_step();
    drain();

    // Reset mid-flight drops the pending response; the next grant behaves normally.
    do_reset();
    renew(0);
    bus.req_valid = 4'b0001;
    cycle();
    bus.req_valid = '0;
    cycle();
    cycle();
    do_reset();
    for (int k = 0; k < LAT; k++) cycle();
    renew(0);
    bus.req_valid = 4'b0001;
    @(negedge clk);
    chk("post_rst_grant", 32'(bus.req_ready), 32'h1);
    model_step();
    bus.req_valid = '0;
    for (int k = 0; k < LAT; k++) cycle();
    @(negedge clk);
    chk("post_rst_rsp", 32'(bus.rsp_valid), 32'h1);
    model_step();

    // Back-to-back on two requesters: grants coincide with own responses.
    do_reset();
    renew(0);
    renew(1);
    bus.req_valid = 4'b0011;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      exp = (c % 6 < 4) ? ((c % 2 == 1) ? 4'b0010 : 4'b0001) : 4'b0000;
      chk("b2b_pattern", 32'(bus.req_ready), 32'(exp));
      model_step();
      if (prev_g >= 0) renew(prev_g);
    end
    drain();

    // Randomized traffic; requests stay stable until accepted.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (prev_g == i) begin
          bus.req_valid[i] = ($urandom_range(0, 3) != 0);
          renew(i);
        end else if (!bus.req_valid[i]) begin
          bus.req_valid[i] = ($urandom_range(0, 2) == 0);
          if (bus.req_valid[i]) renew(i);
        end
      end
      if ($urandom_range(0, 599) == 0) do_reset();
      cycle();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fpadd_share_arbiter.md
FPADD_SHARE_ARBITER -- requirements
Module: fpadd_share_arbiter

Interface
REQ-001 The block SHALL have parameters NUM_REQ, default 4, number of requesters sharing one FP16 add/sub datapath.
REQ-002 The block SHALL have parameters PIPE_LAT, default 5, fixed latency in cycles of the shared adder, from add_in_valid to add_result valid.
REQ-003 The block SHALL have parameters MAX_OUT, default 2, maximum in-flight operations per requester.
REQ-004 The block SHALL have ports clk input 1, the single clock, with all state on its rising edge.
REQ-005 The block SHALL have ports resetn input 1, asynchronous active-low reset.
REQ-006 The block SHALL have ports req_valid input NUM_REQ, one request per requester.
REQ-007 The block SHALL have ports req_ready output NUM_REQ, handshake acceptance.
REQ-008 The block SHALL have ports req_a, req_b input NUM_REQ*16, FP16 operands, slice i belongs to requester i.
REQ-009 The block SHALL have ports req_op input NUM_REQ, 0=add, 1=subtract.
REQ-010 The block SHALL have ports add_in_valid output 1, add_a/add_b output 16, add_op output 1, registered issue to the shared adder.
REQ-011 The block SHALL have ports add_result input 16 and add_flags input 5 (overflow, underflow, inexact, NaN, zero-sum), sampled only in tagged cycles.
REQ-012 The block SHALL have ports rsp_valid output NUM_REQ (one-hot or zero), rsp_data output 16, rsp_flags output 5.
REQ-013 The block SHALL have ports busy output 1, high while any operation is in flight.

Function
REQ-014 Handshake: a transfer for requester i occurs in the cycle where req_valid[i] and req_ready[i] are both 1; requesters SHALL hold operands stable until then.
REQ-015 At most one req_ready bit SHALL be 1 per cycle; req_ready[i] is combinational from req_valid, the round-robin pointer and eligibility.
REQ-016 Requester i is eligible when its outstanding count < MAX_OUT; ineligible requesters SHALL be skipped without consuming priority.
REQ-017 Round-robin: search starts at pointer p; after a grant to i, p SHALL become (i+1) mod NUM_REQ; with no grant, p is unchanged.
REQ-018 A grant at cycle T SHALL drive add_in_valid=1 with add_a/add_b/add_op equal to the granted slice at cycle T+1; otherwise add_in_valid=0 and the operand registers hold.
REQ-019 A tag shift register of depth PIPE_LAT+1 SHALL carry {valid, requester index} from the grant alongside the adder.
REQ-020 The response for a grant at T SHALL appear at T+1+PIPE_LAT: rsp_valid[i]=1 for one cycle, with rsp_data=add_result and rsp_flags=add_flags combinationally passed.
REQ-021 Responses SHALL not be back-pressured; requesters must accept rsp_valid in the cycle it is asserted.
REQ-022 When rsp_valid[i] is asserted, the outstanding count of i SHALL decrement; on a grant to i it SHALL increment; when both occur in one cycle it is unchanged.
REQ-023 rsp_data and rsp_flags SHALL be 0 whenever no rsp_valid bit is 1.
REQ-024 busy SHALL be the OR of all tag-valid bits and add_in_valid.
REQ-025 Sustained throughput SHALL be one grant per cycle while any eligible requester is valid.
REQ-026 Each counter SHALL be clog2(MAX_OUT+1) bits wide and never exceed MAX_OUT or underflow.

Reset
REQ-027 While resetn=0, asynchronously: p=0; all outstanding counts=0; all tags invalid; add_in_valid=0; add_a=add_b=0; add_op=0; rsp_valid=0; busy=0; req_ready=0.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight tags; results emerging from the adder after reset release SHALL produce no rsp_valid.
REQ-029 The first grant after reset release SHALL favour requester 0 when it is valid.

Verification
REQ-030 Single request: req_valid=0001, a=0x3C00, b=0x4000, op=0 at T -> add_in_valid at T+1 with a/b passed; rsp_valid=0001 at T+6 carrying the adder output (0x4200).
REQ-031 All four requesters valid continuously from reset -> grants 0,1,2,3,0,1... one per cycle; each rsp_valid returns in the same order 6 cycles later.
REQ-032 Only requester 2 valid continuously, MAX_OUT=2 -> grants at T and T+1, stall until the first response at T+6, then one grant per response cycle (no counter change in those cycles).
REQ-033 Requester 1 ineligible (count=2) while 1 and 3 are valid with p=1 -> grant goes to 3 and p becomes 0.
REQ-034 resetn pulsed low at T+3 after a grant at T -> all outputs 0 immediately; no rsp_valid at T+6; the next grant proceeds normally.
REQ-035 Grant to 0 coinciding with a response for 0 -> count unchanged, verified over 20 cycles of back-to-back traffic.
